// File: rtl/sb_tx_scheduler_pkg.sv
// Shared types and constants for the sideband TX scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sb_tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } sb_state_e;

    localparam int SB_WORD_W       = 64;
    localparam int SB_SHIFT_CYCLES = 63;
    localparam int SB_GAP_CYCLES   = 32;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

endpackage

// File: rtl/sb_tx_scheduler_if.sv
// Request/serializer bundle between the packet framers, the scheduler and the serializer.
// Latency: n/a (wiring only).
// Backpressure: requesters hold i_req_* until their o_req_grant pulse.
// Ports: i_sb_enable, i_req_valid/has_data/hdr/data in; o_req_grant, o_ser_data,
//        o_ser_enable, o_ser_pack_finished, o_busy, o_pkt_done out (scheduler view).
interface sb_tx_scheduler_if #(
    parameter int N_REQ = 2
);
    import sb_tx_sched_pkg::*;

    logic                          i_sb_enable;
    logic [N_REQ-1:0]              i_req_valid;
    logic [N_REQ-1:0]              i_req_has_data;
    logic [SB_WORD_W*N_REQ-1:0]    i_req_hdr;
    logic [SB_WORD_W*N_REQ-1:0]    i_req_data;
    logic [N_REQ-1:0]              o_req_grant;
    logic [SB_WORD_W-1:0]          o_ser_data;
    logic                          o_ser_enable;
    logic                          o_ser_pack_finished;
    logic                          o_busy;
    logic                          o_pkt_done;

    // Requester/serializer side.
    modport master (
        output i_sb_enable, i_req_valid, i_req_has_data, i_req_hdr, i_req_data,
        input  o_req_grant, o_ser_data, o_ser_enable, o_ser_pack_finished, o_busy, o_pkt_done
    );

    // Scheduler side.
    modport slave (
        input  i_sb_enable, i_req_valid, i_req_has_data, i_req_hdr, i_req_data,
        output o_req_grant, o_ser_data, o_ser_enable, o_ser_pack_finished, o_busy, o_pkt_done
    );

endinterface

// File: rtl/sb_tx_scheduler_arbiter.sv
// Request arbiter: picks one valid requester (round-robin or fixed priority).
// Latency: grant is combinational from i_valid; pointer advances on the i_take edge.
// Backpressure: none; the caller decides when a selection is taken via i_take.
// Ports: i_clk, i_rst (sync, active-high), i_valid, i_take in; o_grant, o_idx, o_any out.
module sb_req_arbiter
    import sb_tx_sched_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int ARB_MODE = ARB_RR,
    parameter int PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_REQ-1:0] i_valid,
    input  logic             i_take,
    output logic [N_REQ-1:0] o_grant,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_any
);

    logic [PTR_W-1:0] r_ptr;
    logic [N_REQ-1:0] w_grant;
    logic [PTR_W-1:0] w_idx;
    logic             w_any;
    int               w_k;

    // Walk the requesters starting at the pointer (or at 0 for fixed priority);
    // the first valid one wins.
    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        w_any   = 1'b0;
        w_k     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            w_k = (ARB_MODE == ARB_FIXED) ? i : ((int'(r_ptr) + i) % N_REQ);
            if (!w_any && i_valid[w_k]) begin
                w_any        = 1'b1;
                w_idx        = PTR_W'(w_k);
                w_grant[w_k] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= '0;
        end else if (i_take && (ARB_MODE == ARB_RR)) begin
            r_ptr <= PTR_W'((int'(w_idx) + 1) % N_REQ);
        end
    end

    assign o_grant = w_grant;
    assign o_idx   = w_idx;
    assign o_any   = w_any;

endmodule

// File: rtl/sb_tx_scheduler.sv
// Sideband TX scheduler: arbitrates packet sources and sequences LOAD/SHIFT/GAP per 64-bit word.
// Latency: grant in IDLE cycle t, LOAD at t+1, each word occupies 1+63+GAP_CYCLES cycles.
// Backpressure: requesters hold their request until granted; requests are ignored while busy.
// Ports: i_pll_clk, i_rst (sync, active-high), bus (sb_tx_scheduler_if.slave).
module sb_tx_scheduler
    import sb_tx_sched_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int GAP_CYCLES = SB_GAP_CYCLES,
    parameter int ARB_MODE   = ARB_RR
) (
    input  logic               i_pll_clk,
    input  logic               i_rst,
    sb_tx_scheduler_if.slave   bus
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    sb_state_e              r_state;
    logic [5:0]             r_shift_cnt;
    logic [GAP_W-1:0]       r_gap_cnt;
    logic                   r_word_idx;
    logic                   r_has_data;
    logic [SB_WORD_W-1:0]   r_data;
    logic [SB_WORD_W-1:0]   r_ser_data;
    logic                   r_ser_enable;
    logic                   r_pack_fin;
    logic                   r_pkt_done;

    logic [N_REQ-1:0]       w_arb_grant;
    logic [PTR_W-1:0]       w_arb_idx;
    logic                   w_arb_any;
    logic                   w_take;
    logic                   w_last_word;
    logic                   w_gap_last;
    logic                   w_gap_prelast;

    // A grant is only issued from IDLE; i_req_* are don't-care in every other state.
    assign w_take = (r_state == IDLE) && !i_rst && bus.i_sb_enable && w_arb_any;

    // The current word is the last one unless it is the header of a packet with data.
    assign w_last_word   = r_word_idx || !r_has_data;
    assign w_gap_last    = (int'(r_gap_cnt) == GAP_CYCLES - 1);
    assign w_gap_prelast = (int'(r_gap_cnt) == GAP_CYCLES - 2);

    sb_req_arbiter #(
        .N_REQ    (N_REQ),
        .ARB_MODE (ARB_MODE),
        .PTR_W    (PTR_W)
    ) u_arb (
        .i_clk   (i_pll_clk),
        .i_rst   (i_rst),
        .i_valid (bus.i_req_valid),
        .i_take  (w_take),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_any   (w_arb_any)
    );

    always_ff @(posedge i_pll_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_shift_cnt  <= '0;
            r_gap_cnt    <= '0;
            r_word_idx   <= 1'b0;
            r_has_data   <= 1'b0;
            r_data       <= '0;
            r_ser_data   <= '0;
            r_ser_enable <= 1'b0;
            r_pack_fin   <= 1'b0;
            r_pkt_done   <= 1'b0;
        end else begin
            r_pkt_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_state      <= LOAD;
                        r_ser_data   <= bus.i_req_hdr[int'(w_arb_idx)*SB_WORD_W +: SB_WORD_W];
                        r_data       <= bus.i_req_data[int'(w_arb_idx)*SB_WORD_W +: SB_WORD_W];
                        r_has_data   <= bus.i_req_has_data[w_arb_idx];
                        r_word_idx   <= 1'b0;
                        r_ser_enable <= 1'b1;
                    end
                end
                LOAD: begin
                    r_state      <= SHIFT;
                    r_shift_cnt  <= '0;
                    r_ser_enable <= 1'b0;
                end
                SHIFT: begin
                    if (r_shift_cnt == 6'(SB_SHIFT_CYCLES - 1)) begin
                        r_state    <= GAP;
                        r_gap_cnt  <= '0;
                        r_pack_fin <= 1'b1;
                        // Single-cycle gap: the first gap cycle is also the last.
                        r_pkt_done <= (GAP_CYCLES == 1) && w_last_word;
                    end else begin
                        r_shift_cnt <= r_shift_cnt + 6'd1;
                    end
                end
                GAP: begin
                    if (w_gap_last) begin
                        r_pack_fin <= 1'b0;
                        if (!w_last_word) begin
                            r_word_idx   <= 1'b1;
                            r_state      <= LOAD;
                            r_ser_enable <= 1'b1;
                            r_ser_data   <= r_data;
                        end else begin
                            r_state    <= IDLE;
                            r_ser_data <= '0;
                        end
                    end else begin
                        r_gap_cnt  <= r_gap_cnt + GAP_W'(1);
                        // Registered pulse: raise it on the edge into the final gap cycle.
                        r_pkt_done <= w_gap_prelast && w_last_word;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.o_req_grant         = w_take ? w_arb_grant : '0;
    assign bus.o_ser_data          = r_ser_data;
    assign bus.o_ser_enable        = r_ser_enable;
    assign bus.o_ser_pack_finished = r_pack_fin;
    assign bus.o_busy              = (r_state != IDLE);
    assign bus.o_pkt_done          = r_pkt_done;

endmodule

// File: tb/tb_sb_tx_scheduler.sv
// Directed bench for sb_tx_scheduler: a round-robin instance and a fixed-priority instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_sb_tx_scheduler;
    import sb_tx_sched_pkg::*;

    localparam int N   = 2;
    localparam int GAP = 32;

    localparam logic [63:0] HDR_A  = 64'hA5A5_0000_FFFF_1234;
    localparam logic [63:0] HDR_B  = 64'h1111_2222_3333_4444;
    localparam logic [63:0] DATA_B = 64'hDEAD_BEEF_0123_4567;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    sb_tx_scheduler_if #(.N_REQ(N)) bus0();
    sb_tx_scheduler_if #(.N_REQ(N)) bus1();

    sb_tx_scheduler #(.N_REQ(N), .GAP_CYCLES(GAP), .ARB_MODE(ARB_RR)) dut0 (
        .i_pll_clk (clk),
        .i_rst     (rst),
        .bus       (bus0)
    );

    sb_tx_scheduler #(.N_REQ(N), .GAP_CYCLES(GAP), .ARB_MODE(ARB_FIXED)) dut1 (
        .i_pll_clk (clk),
        .i_rst     (rst),
        .bus       (bus1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {grant, enable, pack_finished, pkt_done, busy, ser_data}
    function automatic logic [69:0] snap0();
        return {bus0.o_req_grant, bus0.o_ser_enable, bus0.o_ser_pack_finished,
                bus0.o_pkt_done, bus0.o_busy, bus0.o_ser_data};
    endfunction

    function automatic logic [69:0] snap1();
        return {bus1.o_req_grant, bus1.o_ser_enable, bus1.o_ser_pack_finished,
                bus1.o_pkt_done, bus1.o_busy, bus1.o_ser_data};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus0.i_sb_enable = 1'b1; bus0.i_req_valid = '0; bus0.i_req_has_data = '0;
        bus0.i_req_hdr = '0;     bus0.i_req_data = '0;
        bus1.i_sb_enable = 1'b1; bus1.i_req_valid = '0; bus1.i_req_has_data = '0;
        bus1.i_req_hdr = '0;     bus1.i_req_data = '0;
        repeat (3) tick();
        n_tests++;
        if (snap0() !== 70'd0) begin
            n_fail++; $display("FAIL reset_dut0 got=%h exp=0", snap0());
        end
        n_tests++;
        if (snap1() !== 70'd0) begin
            n_fail++; $display("FAIL reset_dut1 got=%h exp=0", snap1());
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_hdr_only();
        logic [69:0] exp;
        bus0.i_req_hdr      = {HDR_B, HDR_A};
        bus0.i_req_has_data = 2'b00;
        bus0.i_req_valid    = 2'b01;
        #1;
        n_tests++;
        if (bus0.o_req_grant !== 2'b01) begin
            n_fail++; $display("FAIL hdr_grant got=%b exp=01", bus0.o_req_grant);
        end
        tick();
        bus0.i_req_valid = 2'b00;
        for (int c = 1; c <= 97; c++) begin
            exp = {2'b00, (c == 1), (c >= 65 && c <= 96), (c == 96), (c <= 96),
                   (c <= 96) ? HDR_A : 64'd0};
            n_tests++;
            if (snap0() !== exp) begin
                n_fail++; $display("FAIL hdr_only_t+%0d got=%h exp=%h", c, snap0(), exp);
            end
            tick();
        end
    endtask

    task automatic test_hdr_data();
        logic [69:0] exp;
        logic [63:0] dat;
        bus0.i_req_hdr      = {HDR_B, HDR_A};
        bus0.i_req_data     = {DATA_B, 64'd0};
        bus0.i_req_has_data = 2'b10;
        bus0.i_req_valid    = 2'b10;
        #1;
        n_tests++;
        if (bus0.o_req_grant !== 2'b10) begin
            n_fail++; $display("FAIL data_grant got=%b exp=10", bus0.o_req_grant);
        end
        tick();
        bus0.i_req_valid = 2'b00;
        for (int c = 1; c <= 193; c++) begin
            dat = (c <= 96) ? HDR_B : ((c <= 192) ? DATA_B : 64'd0);
            exp = {2'b00, (c == 1 || c == 97),
                   ((c >= 65 && c <= 96) || (c >= 161 && c <= 192)),
                   (c == 192), (c <= 192), dat};
            n_tests++;
            if (snap0() !== exp) begin
                n_fail++; $display("FAIL hdr_data_t+%0d got=%h exp=%h", c, snap0(), exp);
            end
            tick();
        end
        bus0.i_req_has_data = 2'b00;
    endtask

    task automatic test_back_to_back();
        logic [1:0] g0 [4];
        logic [1:0] g1 [4];
        int t0 [4];
        int t1 [4];
        int n0 = 0;
        int n1 = 0;
        int k  = 0;
        bus0.i_req_hdr = {HDR_B, HDR_A}; bus0.i_req_has_data = 2'b00; bus0.i_req_valid = 2'b11;
        bus1.i_req_hdr = {HDR_B, HDR_A}; bus1.i_req_has_data = 2'b00; bus1.i_req_valid = 2'b11;
        #1;
        for (int cyc = 0; cyc < 320; cyc++) begin
            if (bus0.o_req_grant != 2'b00 && n0 < 4) begin
                g0[n0] = bus0.o_req_grant; t0[n0] = cyc; n0++;
            end
            if (bus1.o_req_grant != 2'b00 && n1 < 4) begin
                g1[n1] = bus1.o_req_grant; t1[n1] = cyc; n1++;
            end
            tick();
        end
        bus0.i_req_valid = 2'b00;
        bus1.i_req_valid = 2'b00;
        n_tests++;
        if (n0 != 4 || n1 != 4) begin
            n_fail++; $display("FAIL b2b_grant_count got=%0d/%0d exp=4/4", n0, n1);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (g0[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                    n_fail++; $display("FAIL rr_order[%0d] got=%b exp=%b", i, g0[i],
                                       (i % 2 == 0) ? 2'b01 : 2'b10);
                end
                n_tests++;
                if (g1[i] !== 2'b01) begin
                    n_fail++; $display("FAIL fixed_order[%0d] got=%b exp=01", i, g1[i]);
                end
                if (i > 0) begin
                    n_tests++;
                    if (t0[i] - t0[i-1] != 97 || t1[i] - t1[i-1] != 97) begin
                        n_fail++; $display("FAIL b2b_spacing[%0d] got=%0d/%0d exp=97", i,
                                           t0[i] - t0[i-1], t1[i] - t1[i-1]);
                    end
                end
            end
        end
        while ((bus0.o_busy || bus1.o_busy) && k < 300) begin tick(); k++; end
        n_tests++;
        if (bus0.o_busy || bus1.o_busy) begin
            n_fail++; $display("FAIL b2b_drain got=busy exp=idle");
        end
        tick();
    endtask

    task automatic test_enable();
        int done_at = -1;
        int bad = 0;
        bus0.i_req_hdr = {HDR_B, HDR_A};
        bus0.i_sb_enable = 1'b0;
        bus0.i_req_valid = 2'b01;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_tests++;
            if (bus0.o_req_grant !== 2'b00 || bus0.o_busy !== 1'b0) begin
                n_fail++; $display("FAIL enable_off_%0d got=%b/%b exp=00/0", c,
                                   bus0.o_req_grant, bus0.o_busy);
            end
            tick();
        end
        bus0.i_sb_enable = 1'b1;
        #1;
        n_tests++;
        if (bus0.o_req_grant !== 2'b01) begin
            n_fail++; $display("FAIL enable_on_grant got=%b exp=01", bus0.o_req_grant);
        end
        tick();
        bus0.i_req_valid = 2'b00;
        for (int c = 1; c <= 96; c++) begin
            if (c == 10) begin
                bus0.i_sb_enable = 1'b0;
                bus0.i_req_valid = 2'b01;
            end
            if (bus0.o_pkt_done === 1'b1 && done_at < 0) done_at = c;
            tick();
        end
        n_tests++;
        if (done_at != 96) begin
            n_fail++; $display("FAIL enable_drop_done got=t+%0d exp=t+96", done_at);
        end
        for (int c = 0; c < 20; c++) begin
            if (bus0.o_req_grant !== 2'b00 || bus0.o_busy !== 1'b0) bad++;
            tick();
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL enable_drop_no_grant got=%0d exp=0", bad);
        end
        bus0.i_req_valid = 2'b00;
        bus0.i_sb_enable = 1'b1;
        tick();
    endtask

    task automatic test_rst_mid();
        int k = 0;
        bus0.i_req_valid = 2'b01;
        #1;
        n_tests++;
        if (bus0.o_req_grant !== 2'b01) begin
            n_fail++; $display("FAIL rst_pre_grant got=%b exp=01", bus0.o_req_grant);
        end
        tick();
        bus0.i_req_valid = 2'b00;
        repeat (10) tick();
        rst = 1'b1;
        bus0.i_req_valid = 2'b11;
        tick();
        n_tests++;
        if (snap0() !== 70'd0) begin
            n_fail++; $display("FAIL rst_mid_outputs got=%h exp=0", snap0());
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus0.o_req_grant !== 2'b01) begin
            n_fail++; $display("FAIL rst_ptr_grant got=%b exp=01", bus0.o_req_grant);
        end
        tick();
        bus0.i_req_valid = 2'b00;
        while (bus0.o_busy && k < 200) begin tick(); k++; end
        n_tests++;
        if (bus0.o_busy) begin
            n_fail++; $display("FAIL rst_drain got=busy exp=idle");
        end
        tick();
    endtask

    task automatic test_withdraw();
        int bad = 0;
        int k = 0;
        bus0.i_req_valid = 2'b01;
        #1;
        n_tests++;
        if (bus0.o_req_grant !== 2'b01) begin
            n_fail++; $display("FAIL withdraw_grant0 got=%b exp=01", bus0.o_req_grant);
        end
        tick();
        bus0.i_req_valid = 2'b00;
        repeat (20) tick();
        bus0.i_req_valid = 2'b10;
        for (int c = 0; c < 5; c++) begin
            if (bus0.o_req_grant[1] === 1'b1) bad++;
            tick();
        end
        bus0.i_req_valid = 2'b00;
        while (k < 100) begin
            if (bus0.o_req_grant[1] === 1'b1) bad++;
            tick(); k++;
        end
        n_tests++;
        if (bad != 0 || bus0.o_busy !== 1'b0) begin
            n_fail++; $display("FAIL withdraw_no_grant got=%0d/%b exp=0/0", bad, bus0.o_busy);
        end
    endtask

    initial begin
        test_reset();
        test_hdr_only();
        test_hdr_data();
        test_back_to_back();
        test_enable();
        test_rst_mid();
        test_withdraw();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
